// File: rtl/fx68k_bus_responder.sv
// 68000 asynchronous-bus slave for the fx68k core: word-wide RAM window, DTACKn/BERRn/VPAn, IACK.
// Optional interrupt-acknowledge support is enabled with `define FX68K_RESP_IACK_EN.
module fx68k_bus_responder #(
  parameter int          ADDR_BITS   = 12,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        extResetn,
  input  logic        enPhi1,
  input  logic        enPhi2,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        eRWn,
  input  logic [2:0]  FC,
  input  logic [23:1] eab,
  input  logic [15:0] iEdb,
  output logic [15:0] oEdb,
  output logic        DTACKn,
  output logic        BERRn,
  output logic        VPAn,
  input  logic [2:0]  iplReq,
  input  logic [7:0]  intVector,
  input  logic        useAutovec,
  output logic [2:0]  IPLn
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_ACK, ST_RMCW, ST_ERR, ST_IACK
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [15:0]            mem [0:(1<<ADDR_BITS)-1];
  logic                   hit;
  logic                   ds_any;
  logic                   wr_en;
  logic                   unused_in;

  assign hit    = (eab[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign ds_any = !UDSn || !LDSn;

  // The single data-phase write happens on the WAIT->ACK tick; reset blocks it.
  assign wr_en = extResetn && enPhi2 && (state == ST_WAIT) && !ASn &&
                 (cnt == 4'd0) && ds_any && !eRWn;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!UDSn) mem[idx_q][15:8] <= iEdb[15:8];
      if (!LDSn) mem[idx_q][7:0]  <= iEdb[7:0];
    end
  end

`ifdef FX68K_RESP_IACK_EN
  assign unused_in = &{1'b0, enPhi1};
`else
  assign unused_in = &{1'b0, enPhi1, FC, iplReq, intVector, useAutovec};
  assign VPAn      = 1'b1;
  assign IPLn      = 3'b111;
`endif

  always_ff @(posedge clk) begin
    if (!extResetn) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      idx_q  <= '0;
      oEdb   <= 16'h0000;
      DTACKn <= 1'b1;
      BERRn  <= 1'b1;
`ifdef FX68K_RESP_IACK_EN
      VPAn   <= 1'b1;
      IPLn   <= 3'b111;
`endif
    end else if (enPhi2) begin
`ifdef FX68K_RESP_IACK_EN
      IPLn <= ~iplReq;
`endif
      case (state)
        ST_IDLE: begin
          if (!ASn) begin
            idx_q <= eab[ADDR_BITS:1];
`ifdef FX68K_RESP_IACK_EN
            if (FC == 3'b111) state <= ST_IACK;
            else
`endif
            if (hit) begin
              state <= ST_WAIT;
              cnt   <= WS;
            end else begin
              state <= ST_ERR;
              BERRn <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (ASn) begin
            state <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (ds_any) begin
            if (eRWn) oEdb <= mem[idx_q];
            DTACKn <= 1'b0;
            state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (ASn) begin
            DTACKn <= 1'b1;
            oEdb   <= 16'h0000;
            state  <= ST_IDLE;
          end else if (UDSn && LDSn) begin
            // Strobes dropped with AS held: read-modify-write, wait for the write phase.
            DTACKn <= 1'b1;
            oEdb   <= 16'h0000;
            state  <= ST_RMCW;
          end
        end
        ST_RMCW: begin
          if (ASn) begin
            state <= ST_IDLE;
          end else if (ds_any) begin
            state <= ST_WAIT;
            cnt   <= WS;
          end
        end
        ST_ERR: begin
          if (ASn) begin
            BERRn <= 1'b1;
            state <= ST_IDLE;
          end
        end
`ifdef FX68K_RESP_IACK_EN
        ST_IACK: begin
          if (ASn) begin
            DTACKn <= 1'b1;
            VPAn   <= 1'b1;
            oEdb   <= 16'h0000;
            state  <= ST_IDLE;
          end else if (DTACKn && VPAn) begin
            // idx_q[2:0] holds the acknowledged level from A3..A1.
            if (iplReq == 3'd0 || idx_q[2:0] != iplReq) begin
              BERRn <= 1'b0;
              state <= ST_ERR;
            end else if (useAutovec) begin
              VPAn <= 1'b0;
            end else begin
              oEdb   <= {8'hFF, intVector};
              DTACKn <= 1'b0;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx68k_bus_responder.sv
// Self-checking bench for fx68k_bus_responder: directed bus cycles plus random cycles vs a word-array model.
module tb_fx68k_bus_responder;

`ifdef FX68K_RESP_IACK_EN
  localparam bit IACK_EN = 1'b1;
`else
  localparam bit IACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enPhi2 = 1'b0;
  logic        enPhi1;
  logic        as0, as3, UDSn, LDSn, eRWn, useAutovec;
  logic [2:0]  FC, iplReq;
  logic [23:1] eab;
  logic [15:0] iEdb;
  logic [7:0]  intVector;

  logic [15:0] oedb0, oedb3, d_oedb;
  logic        dtack0, berr0, vpa0, dtack3, berr3, vpa3;
  logic        d_dtack, d_berr, d_vpa;
  logic [2:0]  ipl0, ipl3;
  logic        sel3;

  int n_asrt = 0;
  int n_fail = 0;
  int last_lat;
  bit [15:0] ref_mem [0:4095];
  bit        ref_valid [0:4095];

  always #5 clk = ~clk;
  always @(negedge clk) enPhi2 = ~enPhi2;
  assign enPhi1 = ~enPhi2;

  assign d_oedb  = sel3 ? oedb3  : oedb0;
  assign d_dtack = sel3 ? dtack3 : dtack0;
  assign d_berr  = sel3 ? berr3  : berr0;
  assign d_vpa   = sel3 ? vpa3   : vpa0;

  fx68k_bus_responder #(.ADDR_BITS(12), .BASE_ADDR(24'h000000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .extResetn(rst_n), .enPhi1(enPhi1), .enPhi2(enPhi2),
    .ASn(as0), .UDSn(UDSn), .LDSn(LDSn), .eRWn(eRWn), .FC(FC), .eab(eab),
    .iEdb(iEdb), .oEdb(oedb0), .DTACKn(dtack0), .BERRn(berr0), .VPAn(vpa0),
    .iplReq(iplReq), .intVector(intVector), .useAutovec(useAutovec), .IPLn(ipl0));

  fx68k_bus_responder #(.ADDR_BITS(12), .BASE_ADDR(24'h000000), .WAIT_STATES(3)) dut3 (
    .clk(clk), .extResetn(rst_n), .enPhi1(enPhi1), .enPhi2(enPhi2),
    .ASn(as3), .UDSn(UDSn), .LDSn(LDSn), .eRWn(eRWn), .FC(FC), .eab(eab),
    .iEdb(iEdb), .oEdb(oedb3), .DTACKn(dtack3), .BERRn(berr3), .VPAn(vpa3),
    .iplReq(iplReq), .intVector(intVector), .useAutovec(useAutovec), .IPLn(ipl3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next clk edge that has enPhi2 set.
  task automatic tick();
    @(posedge clk);
    while (!enPhi2) @(posedge clk);
    #1;
  endtask

  // resp: 0 = DTACKn, 1 = BERRn, 2 = VPAn, 3 = no answer within the budget
  task automatic bus_cycle(input bit s3, input logic [23:0] ba, input logic [2:0] fc,
                           input logic rw, input logic u, input logic l, input logic [15:0] wd,
                           output logic [15:0] rd, output int resp, output int lat);
    int nlow;
    sel3 = s3;
    eab = ba[23:1]; FC = fc; eRWn = rw; iEdb = wd;
    if (s3) as3 = 1'b0; else as0 = 1'b0;
    tick();
    UDSn = u; LDSn = l;
    lat = 0; resp = 3;
    for (int i = 0; i < 40; i++) begin
      nlow = int'(!d_dtack) + int'(!d_berr) + int'(!d_vpa);
      chk("exclusive", 32'(nlow <= 1), 32'd1);
      if (!d_dtack) begin resp = 0; break; end
      if (!d_berr)  begin resp = 1; break; end
      if (!d_vpa)   begin resp = 2; break; end
      tick();
      lat++;
    end
    rd = d_oedb;
    as0 = 1'b1; as3 = 1'b1; UDSn = 1'b1; LDSn = 1'b1; eRWn = 1'b1;
    tick();
    chk("release", {13'd0, d_dtack, d_berr, d_vpa, d_oedb}, {13'd0, 3'b111, 16'h0000});
  endtask

  task automatic do_cycle(input string tag, input bit s3, input logic [23:0] ba,
                          input logic [2:0] fc, input logic rw, input logic u, input logic l,
                          input logic [15:0] wd);
    int eresp, elat, resp, lat, idx;
    logic [15:0] erd, rd;
    bit check_data;
    check_data = 1'b0;
    erd = 16'h0000;
    idx = int'(ba[23:1]);
    if (IACK_EN && fc == 3'd7) begin
      elat = 1;
      if (iplReq == 3'd0 || ba[3:1] != iplReq) eresp = 1;
      else if (useAutovec) eresp = 2;
      else begin
        eresp = 0; erd = {8'hFF, intVector}; check_data = 1'b1;
      end
    end else if (ba < 24'h002000) begin
      eresp = 0;
      elat  = (s3 ? 3 : 0) + 1;
      if (!s3) begin
        if (rw) begin
          check_data = ref_valid[idx];
          erd = ref_mem[idx];
        end else begin
          if (!u) ref_mem[idx][15:8] = wd[15:8];
          if (!l) ref_mem[idx][7:0]  = wd[7:0];
          ref_valid[idx] = ref_valid[idx] | (!u && !l);
        end
      end
    end else begin
      eresp = 1; elat = 0;
    end
    bus_cycle(s3, ba, fc, rw, u, l, wd, rd, resp, lat);
    last_lat = lat;
    chk({tag, ".resp"}, 32'(resp), 32'(eresp));
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    if (check_data) chk({tag, ".data"}, {16'd0, rd}, {16'd0, erd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int r;
    logic [23:0] ba;
    logic [2:0]  fc;
    logic        rw, u, l;
    logic [1:0]  ds;

    sel3 = 1'b0; as0 = 1'b1; as3 = 1'b1; UDSn = 1'b1; LDSn = 1'b1; eRWn = 1'b1;
    FC = 3'd5; eab = '0; iEdb = '0; iplReq = 3'd0; intVector = 8'h00; useAutovec = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst.dtack", 32'(dtack0), 32'd1);
    chk("rst.berr", 32'(berr0), 32'd1);
    chk("rst.vpa", 32'(vpa0), 32'd1);
    chk("rst.oedb", 32'(oedb0), 32'd0);
    chk("rst.ipl", 32'(ipl0), 32'd7);

    iplReq = 3'd5;
    tick();
    chk("ipl.follow", 32'(ipl0), IACK_EN ? 32'd2 : 32'd7);
    iplReq = 3'd0;

    // Preload and basic read
    do_cycle("pre0", 0, 24'h000000, 3'd5, 1'b0, 1'b0, 1'b0, 16'h7E57);
    do_cycle("pre10", 0, 24'h000010, 3'd5, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    do_cycle("rd10", 0, 24'h000010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    l0 = last_lat;

    // Upper-lane write over 0x1234
    do_cycle("pre20", 0, 24'h000020, 3'd5, 1'b0, 1'b0, 1'b0, 16'h1234);
    do_cycle("wr20u", 0, 24'h000020, 3'd5, 1'b0, 1'b0, 1'b1, 16'hA55A);
    do_cycle("rd20", 0, 24'h000020, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wr20u.model", 32'(ref_mem[16]), 32'h0000A534);

    // Three wait states
    do_cycle("rd10ws3", 1, 24'h000010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("ws3.delta", 32'(last_lat - l0), 32'd3);

    // Outside the window; 0x800000 aliases index 0 if decode were broken
    do_cycle("miss_wr", 0, 24'h800000, 3'd5, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    do_cycle("miss_rd", 0, 24'h800000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_cycle("rd0", 0, 24'h000000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Interrupt acknowledge, level 5
    iplReq = 3'd5; intVector = 8'h40; useAutovec = 1'b0;
    do_cycle("iack_vec", 0, 24'hFFFFFA, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000);
    useAutovec = 1'b1;
    do_cycle("iack_auto", 0, 24'hFFFFFA, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000);
    useAutovec = 1'b0; iplReq = 3'd3;
    do_cycle("iack_spur", 0, 24'hFFFFFA, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000);
    iplReq = 3'd0;
    do_cycle("iack_none", 0, 24'hFFFFFA, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Read-modify-write at 0x30
    do_cycle("pre30", 0, 24'h000030, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0011);
    sel3 = 1'b0;
    eab = 23'h000018; FC = 3'd5; eRWn = 1'b1; as0 = 1'b0;
    tick();
    UDSn = 1'b0; LDSn = 1'b0;
    tick();
    chk("rmw.pulse1", 32'(dtack0), 32'd0);
    chk("rmw.rdata", 32'(oedb0), 32'h0011);
    UDSn = 1'b1; LDSn = 1'b1;
    tick();
    chk("rmw.gap", 32'(dtack0), 32'd1);
    eRWn = 1'b0; iEdb = 16'h0091; LDSn = 1'b0;
    tick();
    chk("rmw.wait", 32'(dtack0), 32'd1);
    tick();
    chk("rmw.pulse2", 32'(dtack0), 32'd0);
    as0 = 1'b1; LDSn = 1'b1; eRWn = 1'b1;
    tick();
    chk("rmw.end", 32'(dtack0), 32'd1);
    ref_mem[24][7:0] = 8'h91;
    do_cycle("rd30", 0, 24'h000030, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rd30.model", 32'(ref_mem[24]), 32'h00000091);

    // Reset while ACK is held on a read, applied on a non-tick edge
    eab = 23'h000008; FC = 3'd5; eRWn = 1'b1; as0 = 1'b0;
    tick();
    UDSn = 1'b0; LDSn = 1'b0;
    tick();
    chk("rstack.pre", 32'(dtack0), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstack.dtack", 32'(dtack0), 32'd1);
    chk("rstack.oedb", 32'(oedb0), 32'd0);
    rst_n = 1'b1; as0 = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    tick();

    // Reset during WAIT of a write: RAM must keep its old contents
    do_cycle("pre40", 0, 24'h000040, 3'd5, 1'b0, 1'b0, 1'b0, 16'h5678);
    iplReq = 3'd6;
    eab = 23'h000020; FC = 3'd5; eRWn = 1'b0; iEdb = 16'hFFFF; as0 = 1'b0;
    tick();
    UDSn = 1'b0; LDSn = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstwait.idle", {29'd0, dtack0, berr0, vpa0}, 32'd7);
    chk("rstwait.ipl", 32'(ipl0), 32'd7);
    @(posedge clk); #1;
    rst_n = 1'b1; as0 = 1'b1; UDSn = 1'b1; LDSn = 1'b1; eRWn = 1'b1; iplReq = 3'd0;
    tick();
    do_cycle("rd40", 0, 24'h000040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Random traffic against the model
    for (int k = 0; k < 16; k++)
      do_cycle("rndpre", 0, 24'(k * 2), 3'd5, 1'b0, 1'b0, 1'b0, 16'($urandom));
    for (int k = 0; k < 60; k++) begin
      r  = int'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ds = 2'($urandom_range(0, 2));
      u  = ds[1];
      l  = ds[0];
      fc = (r[0]) ? 3'd1 : 3'd5;
      if (r == 0) begin
        ba = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      end else if (r == 1) begin
        ba = {20'hFFFFF, 3'($urandom_range(1, 7)), 1'b0};
        fc = 3'd7;
        rw = 1'b1;
        iplReq = 3'($urandom_range(0, 7));
        intVector = 8'($urandom);
        useAutovec = 1'($urandom_range(0, 1));
      end else begin
        ba = {19'h0, 4'($urandom_range(0, 15)), 1'b0};
      end
      do_cycle("rnd", 0, ba, fc, rw, u, l, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
